// File: rtl/kart_physics.sv
// Per-frame motion integrator for one kart: steer, then speed, then move, then publish.
// Position is kept in 11.4 fixed point; the renderer sees the integer part only.
module kart_physics #(
   parameter int START_X       = 1024,
   parameter int START_Y       = 1024,
   parameter int START_HEADING = 0,
   parameter int MAX_SPEED     = 31,
   parameter int ACCEL         = 1,
   parameter int BRAKE         = 2,
   parameter int FRICTION      = 1,
   parameter int OFFROAD_TYPE  = 0,
   parameter int OFFROAD_CAP   = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        new_frame_in,
   input  logic        btn_accel_in,
   input  logic        btn_brake_in,
   input  logic        btn_left_in,
   input  logic        btn_right_in,
   input  logic [3:0]  surface_in,
   output logic [10:0] x_out,
   output logic [10:0] y_out,
   output logic [3:0]  heading_out,
   output logic [5:0]  speed_out,
   output logic        busy_out,
   output logic        valid_out
);

   typedef enum logic [2:0] {S_IDLE, S_STEER, S_SPEED, S_MOVE, S_DONE} state_t;

   localparam logic [6:0] P_ACCEL    = 7'(ACCEL);
   localparam logic [6:0] P_BRAKE    = 7'(BRAKE);
   localparam logic [6:0] P_FRICTION = 7'(FRICTION);

   state_t      r_state;
   logic        r_accel, r_brake, r_left, r_right;
   logic [3:0]  r_surface;
   logic [14:0] r_pos_x, r_pos_y;
   logic [3:0]  r_heading;
   logic [5:0]  r_speed;
   logic [10:0] r_x_out, r_y_out;
   logic [3:0]  r_heading_out;
   logic [5:0]  r_speed_out;
   logic        r_busy, r_valid;

   logic [3:0]         w_heading_next;
   logic [6:0]         w_cap, w_spd, w_speed_next;
   logic signed [12:0] w_spd_s, w_cos_s, w_sin_s, w_dx, w_dy;
   logic signed [16:0] w_sum_x, w_sum_y;
   logic [14:0]        w_new_x, w_new_y;

   function automatic logic signed [5:0] cos_lut(input logic [3:0] h);
      case (h)
         4'd0:    cos_lut = 6'sd16;
         4'd1:    cos_lut = 6'sd15;
         4'd2:    cos_lut = 6'sd11;
         4'd3:    cos_lut = 6'sd6;
         4'd4:    cos_lut = 6'sd0;
         4'd5:    cos_lut = -6'sd6;
         4'd6:    cos_lut = -6'sd11;
         4'd7:    cos_lut = -6'sd15;
         4'd8:    cos_lut = -6'sd16;
         4'd9:    cos_lut = -6'sd15;
         4'd10:   cos_lut = -6'sd11;
         4'd11:   cos_lut = -6'sd6;
         4'd12:   cos_lut = 6'sd0;
         4'd13:   cos_lut = 6'sd6;
         4'd14:   cos_lut = 6'sd11;
         default: cos_lut = 6'sd15;
      endcase
   endfunction

   function automatic logic [14:0] clamp15(input logic signed [16:0] v);
      if (v[16])      clamp15 = 15'd0;
      else if (v[15]) clamp15 = 15'h7fff;
      else            clamp15 = v[14:0];
   endfunction

   always_comb begin
      w_heading_next = r_heading;
      if (r_speed != 6'd0 && (r_left ^ r_right))
         w_heading_next = r_left ? r_heading - 4'd1 : r_heading + 4'd1;
   end

   // Speed rules evaluated in 7 bits so no subtraction or addition can wrap.
   assign w_cap = (r_surface == 4'(OFFROAD_TYPE)) ? 7'(OFFROAD_CAP) : 7'(MAX_SPEED);
   assign w_spd = {1'b0, r_speed};

   always_comb begin
      w_speed_next = w_spd;
      if (w_spd > w_cap)
         w_speed_next = (w_spd >= w_cap + P_BRAKE) ? w_spd - P_BRAKE : w_cap;
      else if (r_accel && !r_brake)
         w_speed_next = (w_spd + P_ACCEL >= w_cap) ? w_cap : w_spd + P_ACCEL;
      else if (r_brake)
         w_speed_next = (w_spd >= P_BRAKE) ? w_spd - P_BRAKE : 7'd0;
      else
         w_speed_next = (w_spd >= P_FRICTION) ? w_spd - P_FRICTION : 7'd0;
   end

   assign w_spd_s = $signed({7'd0, r_speed});
   assign w_cos_s = 13'(cos_lut(r_heading));
   assign w_sin_s = 13'(cos_lut(r_heading - 4'd4));
   assign w_dx    = w_spd_s * w_cos_s;
   assign w_dy    = w_spd_s * w_sin_s;
   assign w_sum_x = $signed({2'b00, r_pos_x}) + 17'(w_dx);
   assign w_sum_y = $signed({2'b00, r_pos_y}) + 17'(w_dy);
   assign w_new_x = clamp15(w_sum_x);
   assign w_new_y = clamp15(w_sum_y);

   // NOTE: reset is sampled synchronously, so an update in flight is simply dropped.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state       <= S_IDLE;
         r_accel       <= 1'b0;
         r_brake       <= 1'b0;
         r_left        <= 1'b0;
         r_right       <= 1'b0;
         r_surface     <= 4'd0;
         r_pos_x       <= 15'(START_X * 16);
         r_pos_y       <= 15'(START_Y * 16);
         r_heading     <= 4'(START_HEADING);
         r_speed       <= 6'd0;
         r_x_out       <= 11'(START_X);
         r_y_out       <= 11'(START_Y);
         r_heading_out <= 4'(START_HEADING);
         r_speed_out   <= 6'd0;
         r_busy        <= 1'b0;
         r_valid       <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: if (new_frame_in) begin
               r_accel   <= btn_accel_in;
               r_brake   <= btn_brake_in;
               r_left    <= btn_left_in;
               r_right   <= btn_right_in;
               r_surface <= surface_in;
               r_busy    <= 1'b1;
               r_state   <= S_STEER;
            end
            S_STEER: begin
               r_heading <= w_heading_next;
               r_state   <= S_SPEED;
            end
            S_SPEED: begin
               r_speed <= w_speed_next[5:0];
               r_state <= S_MOVE;
            end
            S_MOVE: begin
               r_pos_x <= w_new_x;
               r_pos_y <= w_new_y;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_x_out       <= r_pos_x[14:4];
               r_y_out       <= r_pos_y[14:4];
               r_heading_out <= r_heading;
               r_speed_out   <= r_speed;
               r_valid       <= 1'b1;
               r_busy        <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign x_out       = r_x_out;
   assign y_out       = r_y_out;
   assign heading_out = r_heading_out;
   assign speed_out   = r_speed_out;
   assign busy_out    = r_busy;
   assign valid_out   = r_valid;

endmodule

// File: tb/tb_kart_physics.sv
// Scoreboard bench for kart_physics: a behavioural model predicts every published frame,
// and a monitor compares each valid_out pulse against the oldest prediction.
module tb_kart_physics;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        new_frame_in = 1'b0;
   logic        btn_accel_in = 1'b0, btn_brake_in = 1'b0;
   logic        btn_left_in = 1'b0, btn_right_in = 1'b0;
   logic [3:0]  surface_in = 4'd1;
   logic [10:0] x_out, y_out;
   logic [3:0]  heading_out;
   logic [5:0]  speed_out;
   logic        busy_out, valid_out;

   kart_physics dut (
      .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in),
      .btn_accel_in(btn_accel_in), .btn_brake_in(btn_brake_in),
      .btn_left_in(btn_left_in), .btn_right_in(btn_right_in),
      .surface_in(surface_in), .x_out(x_out), .y_out(y_out),
      .heading_out(heading_out), .speed_out(speed_out),
      .busy_out(busy_out), .valid_out(valid_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int x, y, h, s, cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   valid_seen = 0;
   int   m_x, m_y, m_h, m_s;

   always @(posedge clk_in) cyc++;

   function automatic int cos_t(input int h);
      int tbl[16] = '{16, 15, 11, 6, 0, -6, -11, -15, -16, -15, -11, -6, 0, 6, 11, 15};
      return tbl[h % 16];
   endfunction

   task automatic model_reset();
      m_x = 1024 * 16; m_y = 1024 * 16; m_h = 0; m_s = 0;
   endtask

   task automatic model_step(input logic a, b, l, r, input int surf);
      int cap, nx, ny;
      if (m_s != 0 && l != r) m_h = l ? (m_h + 15) % 16 : (m_h + 1) % 16;
      cap = (surf == 0) ? 8 : 31;
      if (m_s > cap)    m_s = (m_s - 2 > cap) ? m_s - 2 : cap;
      else if (a && !b) m_s = (m_s + 1 < cap) ? m_s + 1 : cap;
      else if (b)       m_s = (m_s - 2 > 0) ? m_s - 2 : 0;
      else              m_s = (m_s - 1 > 0) ? m_s - 1 : 0;
      nx = m_x + m_s * cos_t(m_h);
      ny = m_y + m_s * cos_t((m_h + 12) % 16);
      m_x = (nx < 0) ? 0 : (nx > 32767) ? 32767 : nx;
      m_y = (ny < 0) ? 0 : (ny > 32767) ? 32767 : ny;
   endtask

   // Monitor: every valid pulse must match the oldest prediction, including its cycle.
   always @(negedge clk_in) begin
      exp_t e;
      if (valid_out === 1'b1) begin
         valid_seen++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid at cycle %0d: got x=%0d y=%0d, required no pulse",
                     cyc, x_out, y_out);
         end else begin
            e = sb.pop_front();
            if (x_out !== 11'(e.x) || y_out !== 11'(e.y) ||
                heading_out !== 4'(e.h) || speed_out !== 6'(e.s)) begin
               errors++;
               $display("FAIL frame_outputs: got x=%0d y=%0d h=%0d s=%0d, required x=%0d y=%0d h=%0d s=%0d",
                        x_out, y_out, heading_out, speed_out, e.x, e.y, e.h, e.s);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++;
               $display("FAIL valid_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
            end
         end
      end
   end

   task automatic frame(input logic a, b, l, r, input logic [3:0] surf, input int gap);
      @(negedge clk_in);
      btn_accel_in = a; btn_brake_in = b; btn_left_in = l; btn_right_in = r;
      surface_in = surf; new_frame_in = 1'b1;
      model_step(a, b, l, r, int'(surf));
      sb.push_back('{m_x >> 4, m_y >> 4, m_h, m_s, cyc + 5});
      @(negedge clk_in);
      new_frame_in = 1'b0;
      for (int i = 0; i < 12 && sb.size() != 0; i++) begin
         @(negedge clk_in);
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: got %0d pending results, required 0", sb.size());
         sb.delete();
      end
      repeat (gap) @(negedge clk_in);
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      model_reset();
      repeat (20) @(negedge clk_in);
      checks += 6;
      if (x_out !== 11'd1024)   begin errors++; $display("FAIL reset_x: got %0d, required 1024", x_out); end
      if (y_out !== 11'd1024)   begin errors++; $display("FAIL reset_y: got %0d, required 1024", y_out); end
      if (heading_out !== 4'd0) begin errors++; $display("FAIL reset_heading: got %0d, required 0", heading_out); end
      if (speed_out !== 6'd0)   begin errors++; $display("FAIL reset_speed: got %0d, required 0", speed_out); end
      if (valid_out !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %0b, required 0", valid_out); end
      if (busy_out !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy_out); end
   endtask

   task automatic test_accel();
      int xs[5] = '{1025, 1027, 1030, 1034, 1039};
      for (int i = 0; i < 5; i++) begin
         frame(1, 0, 0, 0, 4'd1, 100);
         checks++;
         if (speed_out !== 6'(i + 1) || x_out !== 11'(xs[i]) || y_out !== 11'd1024) begin
            errors++;
            $display("FAIL accel_step%0d: got s=%0d x=%0d y=%0d, required s=%0d x=%0d y=1024",
                     i, speed_out, x_out, y_out, i + 1, xs[i]);
         end
      end
   endtask

   task automatic test_steer();
      logic [10:0] x0, y0;
      for (int i = 0; i < 3; i++) frame(0, 1, 0, 0, 4'd1, 2);
      checks++;
      if (speed_out !== 6'd0) begin errors++; $display("FAIL brake_to_zero: got %0d, required 0", speed_out); end
      frame(0, 0, 0, 1, 4'd1, 2);
      checks++;
      if (heading_out !== 4'd0) begin errors++; $display("FAIL steer_at_rest: got %0d, required 0", heading_out); end
      for (int i = 0; i < 5; i++) frame(1, 0, 0, 1, 4'd1, 2);
      checks++;
      if (heading_out !== 4'd4) begin errors++; $display("FAIL steer_right: got %0d, required 4", heading_out); end
      x0 = x_out; y0 = y_out;
      for (int i = 0; i < 2; i++) frame(1, 0, 0, 0, 4'd1, 2);
      checks++;
      if (x_out !== x0 || y_out <= y0) begin
         errors++;
         $display("FAIL heading4_motion: got x=%0d y=%0d, required x=%0d y>%0d", x_out, y_out, x0, y0);
      end
      frame(1, 0, 1, 1, 4'd1, 2);
      checks++;
      if (heading_out !== 4'd4) begin errors++; $display("FAIL steer_both: got %0d, required 4", heading_out); end
   endtask

   task automatic test_saturate();
      logic reached, seen_max;
      for (int i = 0; i < 4; i++) frame(1, 0, 0, 1, 4'd1, 0);
      reached = 1'b0; seen_max = 1'b0;
      for (int i = 0; i < 150 && !reached; i++) begin
         frame(1, 0, 0, 0, 4'd1, 0);
         if (x_out == 11'd2047) seen_max = 1'b1;
         if (x_out == 11'd0) reached = 1'b1;
      end
      for (int i = 0; i < 2; i++) frame(1, 0, 0, 0, 4'd1, 0);
      checks++;
      if (reached !== 1'b1 || seen_max !== 1'b0 || x_out !== 11'd0) begin
         errors++;
         $display("FAIL clamp_low: got x=%0d reached=%0b wrapped=%0b, required x=0 reached=1 wrapped=0",
                  x_out, reached, seen_max);
      end
      for (int i = 0; i < 8; i++) frame(1, 0, 0, 1, 4'd1, 0);
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         frame(1, 0, 0, 0, 4'd1, 0);
         if (x_out == 11'd2047) reached = 1'b1;
      end
      for (int i = 0; i < 2; i++) frame(1, 0, 0, 0, 4'd1, 0);
      checks++;
      if (reached !== 1'b1 || x_out !== 11'd2047 || heading_out !== 4'd0) begin
         errors++;
         $display("FAIL clamp_high: got x=%0d h=%0d reached=%0b, required x=2047 h=0 reached=1",
                  x_out, heading_out, reached);
      end
   endtask

   task automatic test_offroad();
      int seq[8] = '{18, 16, 14, 12, 10, 8, 7, 6};
      frame(0, 0, 0, 0, 4'd1, 0);
      for (int i = 0; i < 5; i++) frame(0, 1, 0, 0, 4'd1, 0);
      checks++;
      if (speed_out !== 6'd20) begin errors++; $display("FAIL offroad_setup: got %0d, required 20", speed_out); end
      for (int i = 0; i < 8; i++) begin
         frame(0, 0, 0, 0, 4'd0, 0);
         checks++;
         if (speed_out !== 6'(seq[i])) begin
            errors++;
            $display("FAIL offroad_decay%0d: got %0d, required %0d", i, speed_out, seq[i]);
         end
      end
      for (int i = 0; i < 4; i++) frame(1, 0, 0, 0, 4'd0, 0);
      checks++;
      if (speed_out !== 6'd8) begin errors++; $display("FAIL offroad_cap: got %0d, required 8", speed_out); end
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_seen;
      @(negedge clk_in);
      btn_accel_in = 1'b1; btn_brake_in = 1'b0; btn_left_in = 1'b0; btn_right_in = 1'b0;
      surface_in = 4'd1; new_frame_in = 1'b1;
      model_step(1, 0, 0, 0, 1);
      sb.push_back('{m_x >> 4, m_y >> 4, m_h, m_s, cyc + 5});
      @(negedge clk_in);
      new_frame_in = 1'b0;
      @(negedge clk_in);
      new_frame_in = 1'b1;
      @(negedge clk_in);
      new_frame_in = 1'b0;
      repeat (15) @(negedge clk_in);
      #1;
      checks++;
      if (valid_seen - v0 != 1 || sb.size() != 0) begin
         errors++;
         $display("FAIL busy_ignore: got %0d pulses %0d pending, required 1 pulse 0 pending",
                  valid_seen - v0, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_abort();
      int v0;
      v0 = valid_seen;
      @(negedge clk_in);
      btn_accel_in = 1'b1; surface_in = 4'd1; new_frame_in = 1'b1;
      @(negedge clk_in);
      new_frame_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      model_reset();
      repeat (10) @(negedge clk_in);
      checks++;
      if (x_out !== 11'd1024 || y_out !== 11'd1024 || heading_out !== 4'd0 ||
          speed_out !== 6'd0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: got x=%0d y=%0d h=%0d s=%0d busy=%0b, required 1024 1024 0 0 0",
                  x_out, y_out, heading_out, speed_out, busy_out);
      end
      checks++;
      if (valid_seen != v0) begin
         errors++;
         $display("FAIL abort_valid: got %0d pulses, required 0", valid_seen - v0);
      end
      frame(1, 0, 0, 0, 4'd1, 2);
      checks++;
      if (x_out !== 11'd1025 || speed_out !== 6'd1) begin
         errors++;
         $display("FAIL after_abort: got x=%0d s=%0d, required x=1025 s=1", x_out, speed_out);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_accel();
      test_steer();
      test_saturate();
      test_offroad();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no completion by cycle %0d, required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
